// File: rtl/serial_adder_if.sv
// serial_adder_if
// Handshake and data bundle for the bit-serial adder.
//   master : drives start/a/b/cin, observes busy/done/sum/cout
//   slave  : the adder itself
//   start  request to add (sampled by the adder only when idle)
//   a, b   WIDTH-bit operands, cin carry-in (captured on accepted start)
//   busy   high while bits are being processed
//   done   one-cycle completion pulse
//   sum    WIDTH-bit registered result, cout registered carry-out
// Optional macro SERIAL_ADDER_OVF_EN adds ovf (signed overflow flag).
interface serial_adder_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;

   modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial WIDTH-bit adder with start/busy/done handshake. One bit of the
// result is produced per clock by a full-adder cell (two half_adder
// instances plus an or_gate); the carry is held in a flop between bits.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   serial_adder_if.slave (start, a, b, cin -> busy, done, sum, cout)
// Parameter WIDTH: operand/result width, legal range 2..32.
// Optional macro SERIAL_ADDER_OVF_EN: adds registered signed-overflow flag
// bus.ovf (carry into MSB xor carry out of MSB), held like sum/cout.
// Latency: start accepted at edge k -> busy for WIDTH cycles, done pulses in
// the cycle after edge k+WIDTH, with sum/cout valid from that cycle on.

// half_adder: single-bit sum and carry of two inputs
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

// or_gate: two-input OR used to merge the half-adder carries
module or_gate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a | b;
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] ra_r;
   logic [WIDTH-1:0] rb_r;
   logic [WIDTH-1:0] res_r;
   logic             carry_r;
   logic [CW-1:0]    count_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_r;
`endif

   // full-adder cell signals
   logic ha0_s_s;
   logic ha0_c_s;
   logic ha1_c_s;
   logic bit_s;
   logic carry_s;

   half_adder u_ha0 (
      .a (ra_r[0]),
      .b (rb_r[0]),
      .s (ha0_s_s),
      .c (ha0_c_s)
   );

   half_adder u_ha1 (
      .a (ha0_s_s),
      .b (carry_r),
      .s (bit_s),
      .c (ha1_c_s)
   );

   // carry-out of the cell is the majority of ra[0], rb[0], carry
   or_gate u_or (
      .a (ha0_c_s),
      .b (ha1_c_s),
      .y (carry_s)
   );

   // control FSM, datapath shift registers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         ra_r    <= '0;
         rb_r    <= '0;
         res_r   <= '0;
         carry_r <= 1'b0;
         count_r <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         sum_r   <= '0;
         cout_r  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  ra_r    <= bus.a;
                  rb_r    <= bus.b;
                  carry_r <= bus.cin;
                  count_r <= '0;
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            RUN: begin
               // operands drain LSB-first; result bits enter at the MSB so
               // after WIDTH shifts bit 0 has landed in position 0
               ra_r    <= {1'b0, ra_r[WIDTH-1:1]};
               rb_r    <= {1'b0, rb_r[WIDTH-1:1]};
               res_r   <= {bit_s, res_r[WIDTH-1:1]};
               carry_r <= carry_s;
               count_r <= count_r + CW'(1);
               if (count_r == LAST) begin
                  sum_r   <= {bit_s, res_r[WIDTH-1:1]};
                  cout_r  <= carry_s;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry_r is the carry into the MSB during the last bit
                  ovf_r   <= carry_r ^ carry_s;
`endif
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else begin
                  busy_r  <= 1'b1;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.ovf  = ovf_r;
`endif

endmodule
